// File: rtl/mod_updown_counter.sv
// Loadable up/down counter with a programmable modulus.
// It can either wrap or saturate at the ends of its range.
// Its terminal-count output (tc) can drive the enable of the next counter in a chain.
// q drives the binary-to-BCD display path directly.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  // Largest legal count. MODULUS <= 2**WIDTH, so this value always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_max, at_min;

  // The range-end tests look at the current count before any increment.
  // Because of this, the WIDTH-bit arithmetic never overflows visibly.
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

  // Next-state logic. Priority order is load, then count, then hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (!load_n) begin
      count_d = (d > MAX_VAL) ? MAX_VAL : d;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          count_d = count_q + ONE;
        end else if (!SATURATE) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - ONE;
        end else if (!SATURATE) begin
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
        end
      end
    end
    // sat is based on the new count, so it rises in the same cycle q reaches a range end.
    sat_d = SATURATE & ((count_d == MAX_VAL) | (count_d == '0));
  end

  // State registers. They clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;
  // tc is combinational so that the next stage in a chain advances on the same edge.
  assign tc   = en & load_n & (up ? at_max : at_min);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed checks of mod_updown_counter in three configurations plus a two-stage chain.
module tb_mod_updown_counter;

  logic clk;
  logic rst_n;

  logic       ln_a, en_a, up_a;
  logic [7:0] d_a, q_a;
  logic       tc_a, w_a, s_a;

  logic       ln_b, en_b, up_b;
  logic [3:0] d_b, q_b;
  logic       tc_b, w_b, s_b;

  logic       ln_s, en_s, up_s;
  logic [3:0] d_s, q_s;
  logic       tc_s, w_s, s_s;

  logic       cas_en;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, w_lo, w_hi, s_lo, s_hi;

  int total = 0;
  int bad   = 0;

  int mods[3] = '{256, 10, 16};
  bit sats[3] = '{1'b0, 1'b0, 1'b1};
  int mq[3];
  bit mw[3];
  bit ms[3];
  bit cur_ln[3];
  bit cur_en[3];
  bit cur_up[3];
  int cur_d[3];

  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .load_n(ln_a), .en(en_a), .up(up_a), .d(d_a),
    .q(q_a), .tc(tc_a), .wrap(w_a), .sat(s_a));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .load_n(ln_b), .en(en_b), .up(up_b), .d(d_b),
    .q(q_b), .tc(tc_b), .wrap(w_b), .sat(s_b));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .load_n(ln_s), .en(en_s), .up(up_s), .d(d_s),
    .q(q_s), .tc(tc_s), .wrap(w_s), .sat(s_s));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .load_n(1'b1), .en(cas_en), .up(1'b1), .d(4'd0),
    .q(q_lo), .tc(tc_lo), .wrap(w_lo), .sat(s_lo));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .load_n(1'b1), .en(tc_lo), .up(1'b1), .d(4'd0),
    .q(q_hi), .tc(tc_hi), .wrap(w_hi), .sat(s_hi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour written as modular or clamped arithmetic on integers.
  function automatic void model_step(input int mod, input bit satm, input int q,
                                     input bit ln, input bit e, input bit u, input int dv,
                                     output int nq, output bit nw);
    nw = 1'b0;
    if (!ln) nq = (dv > mod - 1) ? mod - 1 : dv;
    else if (!e) nq = q;
    else if (satm) begin
      nq = u ? q + 1 : q - 1;
      if (nq < 0) nq = 0;
      if (nq > mod - 1) nq = mod - 1;
    end else begin
      nq = u ? (q + 1) % mod : (q + mod - 1) % mod;
      nw = u ? (nq < q) : (nq > q);
    end
  endfunction

  function automatic logic [31:0] obs_q(input int i);
    case (i)
      0:       return {24'b0, q_a};
      1:       return {28'b0, q_b};
      default: return {28'b0, q_s};
    endcase
  endfunction

  function automatic logic [31:0] obs_w(input int i);
    case (i)
      0:       return {31'b0, w_a};
      1:       return {31'b0, w_b};
      default: return {31'b0, w_s};
    endcase
  endfunction

  function automatic logic [31:0] obs_s(input int i);
    case (i)
      0:       return {31'b0, s_a};
      1:       return {31'b0, s_b};
      default: return {31'b0, s_s};
    endcase
  endfunction

  function automatic logic [31:0] obs_tc(input int i);
    case (i)
      0:       return {31'b0, tc_a};
      1:       return {31'b0, tc_b};
      default: return {31'b0, tc_s};
    endcase
  endfunction

  task automatic set_in(input int i, input bit ln, input bit e, input bit u, input int dv);
    cur_ln[i] = ln;
    cur_en[i] = e;
    cur_up[i] = u;
    cur_d[i]  = dv;
    case (i)
      0: begin ln_a = ln; en_a = e; up_a = u; d_a = dv[7:0]; end
      1: begin ln_b = ln; en_b = e; up_b = u; d_b = dv[3:0]; end
      default: begin ln_s = ln; en_s = e; up_s = u; d_s = dv[3:0]; end
    endcase
  endtask

  // Advance one edge, then check every counter's registered outputs against the model.
  task automatic cyc();
    int nq[3];
    bit nw[3];
    for (int i = 0; i < 3; i++)
      model_step(mods[i], sats[i], mq[i], cur_ln[i], cur_en[i], cur_up[i], cur_d[i], nq[i], nw[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mq[i] = nq[i];
      mw[i] = nw[i];
      ms[i] = sats[i] && (nq[i] == 0 || nq[i] == mods[i] - 1);
      chk($sformatf("q%0d", i),    obs_q(i), mq[i]);
      chk($sformatf("wrap%0d", i), obs_w(i), {31'b0, mw[i]});
      chk($sformatf("sat%0d", i),  obs_s(i), {31'b0, ms[i]});
    end
  endtask

  task automatic chk_tc();
    bit e;
    #1;
    for (int i = 0; i < 3; i++) begin
      e = cur_en[i] && cur_ln[i] && (cur_up[i] ? (mq[i] == mods[i] - 1) : (mq[i] == 0));
      chk($sformatf("tc%0d", i), obs_tc(i), {31'b0, e});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0;
      mw[i] = 1'b0;
      ms[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    cas_en = 1'b0;
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, 1'b0, 1'b1, 0);
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_q%0d", i),   obs_q(i), 0);
      chk($sformatf("rst_w%0d", i),   obs_w(i), 0);
      chk($sformatf("rst_sat%0d", i), obs_s(i), 0);
    end
    #10 rst_n = 1'b1;

    // Reset in the middle of counting. It acts before the next clock edge.
    set_in(0, 1'b0, 1'b1, 1'b1, 36);
    cyc();
    set_in(0, 1'b1, 1'b1, 1'b1, 0);
    cyc();
    chk("pre_rst_q", obs_q(0), 37);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", obs_q(0), 0);
    chk("async_rst_w", obs_w(0), 0);
    #1 rst_n = 1'b1;
    model_reset();
    cyc();
    chk("post_rst_q", obs_q(0), 1);

    // Load has priority over counting. Values above the range are clamped.
    set_in(1, 1'b0, 1'b1, 1'b1, 7);
    cyc();
    chk("load7", obs_q(1), 7);
    set_in(1, 1'b0, 1'b1, 1'b0, 13);
    cyc();
    chk("load13_clamp", obs_q(1), 9);
    chk("load_wrap0", obs_w(1), 0);

    // Counting up with modulus 10 wraps from 9 to 0.
    set_in(1, 1'b0, 1'b0, 1'b1, 8);
    cyc();
    set_in(1, 1'b1, 1'b1, 1'b1, 0);
    chk_tc();
    cyc();
    chk("up_q9", obs_q(1), 9);
    chk_tc();
    chk("up_tc9", obs_tc(1), 1);
    cyc();
    chk("up_q0", obs_q(1), 0);
    chk("up_wrap", obs_w(1), 1);
    cyc();
    chk("up_q1", obs_q(1), 1);
    chk("up_wrap_clr", obs_w(1), 0);

    // Counting down with modulus 10 wraps from 0 to 9.
    set_in(1, 1'b1, 1'b1, 1'b0, 0);
    cyc();
    chk("dn_q0", obs_q(1), 0);
    chk_tc();
    chk("dn_tc0", obs_tc(1), 1);
    cyc();
    chk("dn_q9", obs_q(1), 9);
    chk("dn_wrap", obs_w(1), 1);
    cyc();
    chk("dn_q8", obs_q(1), 8);

    // Saturating counter holds at the top of its range.
    set_in(2, 1'b0, 1'b0, 1'b1, 14);
    cyc();
    set_in(2, 1'b1, 1'b1, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("sat_q15", obs_q(2), 15);
      chk("sat_flag", obs_s(2), 1);
      chk("sat_nowrap", obs_w(2), 0);
    end
    set_in(2, 1'b1, 1'b1, 1'b0, 0);
    cyc();
    chk("sat_q14", obs_q(2), 14);
    chk("sat_clr", obs_s(2), 0);

    // Hold when enable is low.
    set_in(1, 1'b0, 1'b0, 1'b1, 3);
    cyc();
    set_in(1, 1'b1, 1'b0, 1'b1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_q3", obs_q(1), 3);
      chk_tc();
    end

    // Random stimulus on all three configurations.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++)
        set_in(i, $urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0,
               $urandom_range(0, 1) != 0, int'($urandom_range(0, (i == 0) ? 255 : 15)));
      chk_tc();
      cyc();
    end

    // Two-stage decimal chain, counted 25 times from zero.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    cas_en = 1'b1;
    for (int k = 0; k < 25; k++) cyc();
    cas_en = 1'b0;
    #1;
    chk("cas_lo", {28'b0, q_lo}, 5);
    chk("cas_hi", {28'b0, q_hi}, 2);
    chk("cas_lo_w", {31'b0, w_lo}, 0);
    chk("cas_hi_w", {31'b0, w_hi}, 0);
    chk("cas_hi_tc", {31'b0, tc_hi}, 0);
    chk("cas_sat", {30'b0, s_lo, s_hi}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
